// File: rtl/demux_8_32_ctrl_if.sv
// Byte-stream side of the 8->32 demux sequencer: the incoming byte qualifiers and
// the lane-select / word-status outputs that steer the datapath demux.
interface demux_8_32_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             valid_in;
  logic [7:0]       data_in;
  logic             align_en;
  logic             byte_we;
  logic [1:0]       byte_sel;
  logic             word_commit;
  logic             err_partial;
  logic             aligned;
  logic [CNT_W-1:0] word_cnt;

  // The byte source / datapath side.
  modport master (
    output valid_in, data_in, align_en,
    input  byte_we, byte_sel, word_commit, err_partial, aligned, word_cnt
  );

  // The sequencer itself.
  modport slave (
    input  valid_in, data_in, align_en,
    output byte_we, byte_sel, word_commit, err_partial, aligned, word_cnt
  );
endinterface

// File: rtl/demux_8_32_ctrl.sv
// Byte-phase sequencer for the 8->32 receive demux (clk_4f domain): packs four bytes
// per word MSB-first, optionally locks word boundaries to COM, flags and counts words.
module demux_8_32_ctrl #(
  parameter logic [7:0] COM   = 8'hBC,
  parameter int         CNT_W = 16
) (
  input  logic                clk_4f,
  input  logic                reset_L,
  demux_8_32_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    COLLECT = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       idx;
  logic             align_mode;
  logic             word_commit_q;
  logic             err_partial_q;
  logic             aligned_q;
  logic [CNT_W-1:0] word_cnt_q;

  logic             is_com;
  logic             accept;
  logic             realign;
  logic [1:0]       lane_idx;

  assign is_com = (bus.data_in == COM);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    accept  = 1'b0;
    realign = 1'b0;
    unique case (state)
      IDLE:    accept = bus.valid_in && (!bus.align_en || is_com);
      HUNT:    accept = bus.valid_in && is_com;
      COLLECT: begin
        accept  = bus.valid_in;
        realign = bus.valid_in && align_mode && is_com && (idx != 2'd0);
      end
      default: ;
    endcase
  end

  // A realigning COM restarts the word, so it lands in the top lane even though idx != 0.
  assign lane_idx = realign ? 2'd0 : idx;

  // Reset also masks the combinational strobe so nothing is written while held in reset.
  assign bus.byte_we     = accept & reset_L;
  assign bus.byte_sel    = 2'd3 - lane_idx;
  assign bus.word_commit = word_commit_q;
  assign bus.err_partial = err_partial_q;
  assign bus.aligned     = aligned_q;
  assign bus.word_cnt    = word_cnt_q;

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state         <= IDLE;
      idx           <= 2'd0;
      align_mode    <= 1'b0;
      word_commit_q <= 1'b0;
      err_partial_q <= 1'b0;
      aligned_q     <= 1'b0;
      word_cnt_q    <= '0;
    end else begin
      // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
      word_commit_q <= 1'b0;
      err_partial_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.valid_in) begin
            align_mode <= bus.align_en;
            if (!bus.align_en || is_com) begin
              idx       <= 2'd1;
              state     <= COLLECT;
              aligned_q <= 1'b1;
            end else begin
              state <= HUNT;
            end
          end
        end

        HUNT: begin
          if (bus.valid_in && is_com) begin
            idx       <= 2'd1;
            state     <= COLLECT;
            aligned_q <= 1'b1;
          end
        end

        COLLECT: begin
          if (bus.valid_in) begin
            if (realign) begin
              err_partial_q <= 1'b1;
              idx           <= 2'd1;
            end else begin
              idx <= idx + 2'd1;
              if (idx == 2'd3) begin
                word_commit_q <= 1'b1;
                if (word_cnt_q != {CNT_W{1'b1}})
                  word_cnt_q <= word_cnt_q + 1'b1;
              end
            end
          end else if (idx != 2'd0) begin
            // A gap inside a word breaks it; in aligned mode the boundary must be re-found.
            err_partial_q <= 1'b1;
            idx           <= 2'd0;
            if (align_mode) begin
              state     <= HUNT;
              aligned_q <= 1'b0;
            end
          end
        end

        default: begin
          state     <= IDLE;
          idx       <= 2'd0;
          aligned_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_8_32_ctrl.sv
// Self-checking bench for demux_8_32_ctrl: directed vector table, reset and counter
// saturation sequences, and randomized streams against a queue-based word model.
module tb_demux_8_32_ctrl;

  localparam logic [7:0] COM     = 8'hBC;
  localparam int         CNT_MAX = 65535;

  logic clk_4f  = 1'b0;
  logic reset_L = 1'b0;

  demux_8_32_ctrl_if #(.CNT_W(16)) bus ();
  demux_8_32_ctrl_if #(.CNT_W(2))  bus2 ();

  assign bus2.valid_in = bus.valid_in;
  assign bus2.data_in  = bus.data_in;
  assign bus2.align_en = bus.align_en;

  demux_8_32_ctrl #(.COM(COM), .CNT_W(16)) dut (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  demux_8_32_ctrl #(.COM(COM), .CNT_W(2)) dut_small (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .bus     (bus2)
  );

  always #5 clk_4f = ~clk_4f;

  // Datapath demux driven only by the DUT's lane controls.
  logic [31:0] demux_word = '0;
  always @(posedge clk_4f)
    if (bus.byte_we) demux_word[int'(bus.byte_sel)*8 +: 8] <= bus.data_in;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model: bytes of the word being built ----------------
  bit          m_started, m_locked, m_mode, m_commit, m_err;
  logic [7:0]  m_q[$];
  int          m_cnt;
  logic [31:0] m_word;

  task automatic model_reset();
    m_started = 0; m_locked = 0; m_mode = 0; m_commit = 0; m_err = 0;
    m_q.delete(); m_cnt = 0; m_word = '0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit ae,
                            output bit we, output logic [1:0] sel);
    we = 0; sel = 2'd3; m_commit = 0; m_err = 0;
    if (!m_started) begin
      if (v) begin
        m_started = 1;
        m_mode    = ae;
        if (!ae || d == COM) begin m_locked = 1; m_q = {d}; we = 1; end
      end
    end else if (!m_locked) begin
      if (v && d == COM) begin m_locked = 1; m_q = {d}; we = 1; end
    end else if (v) begin
      we = 1;
      if (m_mode && d == COM && m_q.size() != 0) begin
        m_err = 1;
        m_q   = {d};
      end else begin
        sel = 2'(3 - m_q.size());
        m_q.push_back(d);
        if (m_q.size() == 4) begin
          m_commit = 1;
          m_word   = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_q.delete();
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end
    end else if (m_q.size() != 0) begin
      m_err = 1;
      m_q.delete();
      if (m_mode) m_locked = 0;
    end
  endtask

  // ---------------- cycle helpers (start and end at a negedge) ----------------
  task automatic do_reset();
    reset_L      = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    bus.align_en = 1'b0;
    #1;
    check("rst_we",     {31'd0, bus.byte_we},     32'd0);
    check("rst_commit", {31'd0, bus.word_commit}, 32'd0);
    check("rst_err",    {31'd0, bus.err_partial}, 32'd0);
    check("rst_aligned",{31'd0, bus.aligned},     32'd0);
    check("rst_cnt",    {16'd0, bus.word_cnt},    32'd0);
    @(negedge clk_4f);
    reset_L = 1'b1;
    model_reset();
  endtask

  task automatic rand_cycle(input bit v, input logic [7:0] d, input bit ae);
    bit         we;
    logic [1:0] sel;
    bus.valid_in = v; bus.data_in = d; bus.align_en = ae;
    model_step(v, d, ae, we, sel);
    #1;
    check("rnd_we", {31'd0, bus.byte_we}, {31'd0, we});
    if (we) check("rnd_sel", {30'd0, bus.byte_sel}, {30'd0, sel});
    @(posedge clk_4f); #1;
    check("rnd_commit",  {31'd0, bus.word_commit}, {31'd0, m_commit});
    check("rnd_err",     {31'd0, bus.err_partial}, {31'd0, m_err});
    check("rnd_aligned", {31'd0, bus.aligned},     {31'd0, m_locked});
    check("rnd_cnt",     {16'd0, bus.word_cnt},    32'(m_cnt));
    if (m_commit) check("rnd_word", demux_word, m_word);
    @(negedge clk_4f);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;     // reset before applying this vector
    bit          v;
    logic [7:0]  d;
    bit          ae;
    bit          we;
    logic [1:0]  sel;
    bit          commit;  // expected after the posedge
    bit          err;
    bit          al;
    int          cnt;
    bit          chkw;
    logic [31:0] word;
  } vec_t;

  vec_t tbl[$];

  task automatic apply_vec(input vec_t t, input int n);
    string tag;
    tag = $sformatf("vec%0d", n);
    if (t.rst) do_reset();
    bus.valid_in = t.v; bus.data_in = t.d; bus.align_en = t.ae;
    #1;
    check({tag, "_we"}, {31'd0, bus.byte_we}, {31'd0, t.we});
    if (t.we) check({tag, "_sel"}, {30'd0, bus.byte_sel}, {30'd0, t.sel});
    @(posedge clk_4f); #1;
    check({tag, "_commit"},  {31'd0, bus.word_commit}, {31'd0, t.commit});
    check({tag, "_err"},     {31'd0, bus.err_partial}, {31'd0, t.err});
    check({tag, "_aligned"}, {31'd0, bus.aligned},     {31'd0, t.al});
    check({tag, "_cnt"},     {16'd0, bus.word_cnt},    32'(t.cnt));
    if (t.chkw) check({tag, "_word"}, demux_word, t.word);
    @(negedge clk_4f);
  endtask

  int pulses;
  always @(posedge clk_4f) begin
    #1;
    if (bus2.word_commit) pulses++;
  end

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    bus.align_en = 1'b0;
    model_reset();

    //            rst v  d      ae we sel commit err al cnt chkw word
    // 1: plain packing, align off
    tbl.push_back('{1, 1, 8'hEE, 0, 1, 2'd3, 0, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'hFF, 0, 1, 2'd2, 0, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'hFD, 0, 1, 2'd1, 0, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'hCC, 0, 1, 2'd0, 1, 0, 1, 1, 1, 32'hEEFFFDCC});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 2'd3, 0, 0, 1, 1, 0, 32'h0});
    // 2: hunt for COM
    tbl.push_back('{1, 1, 8'h00, 1, 0, 2'd3, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'h12, 1, 0, 2'd3, 0, 0, 0, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'hBC, 1, 1, 2'd3, 0, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'h11, 1, 1, 2'd2, 0, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'h22, 1, 1, 2'd1, 0, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'h33, 1, 1, 2'd0, 1, 0, 1, 1, 1, 32'hBC112233});
    // 3: gap mid-word, align off
    tbl.push_back('{1, 1, 8'hAA, 0, 1, 2'd3, 0, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'h12, 0, 1, 2'd2, 0, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 0, 8'h00, 0, 0, 2'd3, 0, 1, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'h55, 0, 1, 2'd3, 0, 0, 1, 0, 0, 32'h0});
    // 4: realign on COM mid-word
    tbl.push_back('{1, 1, 8'hBC, 1, 1, 2'd3, 0, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'h01, 1, 1, 2'd2, 0, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'hBC, 1, 1, 2'd3, 0, 1, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'h02, 1, 1, 2'd2, 0, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'h03, 1, 1, 2'd1, 0, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{0, 1, 8'h04, 1, 1, 2'd0, 1, 0, 1, 1, 1, 32'hBC020304});
    // gap at a word boundary in aligned mode is legal and keeps lock
    tbl.push_back('{0, 0, 8'h00, 1, 0, 2'd3, 0, 0, 1, 1, 0, 32'h0});

    @(negedge clk_4f);
    foreach (tbl[i]) apply_vec(tbl[i], i);

    // 5: asynchronous reset mid-word, then a clean word
    do_reset();
    bus.valid_in = 1'b1; bus.align_en = 1'b0;
    bus.data_in = 8'hEE; @(negedge clk_4f);
    bus.data_in = 8'hFF; @(negedge clk_4f);
    bus.data_in = 8'hFD;
    #2 reset_L = 1'b0;
    #1;
    check("mid_rst_we",      {31'd0, bus.byte_we},     32'd0);
    check("mid_rst_aligned", {31'd0, bus.aligned},     32'd0);
    check("mid_rst_err",     {31'd0, bus.err_partial}, 32'd0);
    check("mid_rst_commit",  {31'd0, bus.word_commit}, 32'd0);
    @(negedge clk_4f);
    bus.valid_in = 1'b0;
    @(negedge clk_4f);
    reset_L = 1'b1;
    @(negedge clk_4f);
    check("post_rst_err", {31'd0, bus.err_partial}, 32'd0);
    apply_vec('{0, 1, 8'hEE, 0, 1, 2'd3, 0, 0, 1, 0, 0, 32'h0}, 100);
    apply_vec('{0, 1, 8'hFF, 0, 1, 2'd2, 0, 0, 1, 0, 0, 32'h0}, 101);
    apply_vec('{0, 1, 8'hFD, 0, 1, 2'd1, 0, 0, 1, 0, 0, 32'h0}, 102);
    apply_vec('{0, 1, 8'hCC, 0, 1, 2'd0, 1, 0, 1, 1, 1, 32'hEEFFFDCC}, 103);

    // 6: saturating counter on the CNT_W=2 instance
    do_reset();
    pulses = 0;
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < 4; b++) begin
        bus.valid_in = 1'b1; bus.data_in = 8'($urandom); bus.align_en = 1'b0;
        @(posedge clk_4f); #1;
        if (b == 3) begin
          check($sformatf("sat_cnt_w%0d", w), {30'd0, bus2.word_cnt}, (w < 3) ? w + 1 : 3);
          check($sformatf("big_cnt_w%0d", w), {16'd0, bus.word_cnt}, w + 1);
          check($sformatf("sat_commit_w%0d", w), {31'd0, bus2.word_commit}, 32'd1);
        end
        @(negedge clk_4f);
      end
    end
    bus.valid_in = 1'b0;
    @(negedge clk_4f);
    @(negedge clk_4f);
    check("sat_pulses", pulses, 5);
    check("sat_hold", {30'd0, bus2.word_cnt}, 32'd3);

    // Randomized streams against the model
    for (int seg = 0; seg < 10; seg++) begin
      bit mode;
      do_reset();
      mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < 120; c++) begin
        bit         v, ae;
        logic [7:0] d;
        v  = ($urandom_range(0, 7) != 0);
        d  = ($urandom_range(0, 3) == 0) ? COM : 8'($urandom);
        ae = (c < 4) ? mode : 1'($urandom_range(0, 1));
        rand_cycle(v, d, ae);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
